// File: rtl/cell_pkt_pkg.sv
// Shared constants and types for the cell packet checker: header layout,
// default magic value, counter width and the write-side FSM states.
package cell_pkt_pkg;

  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;

  localparam int unsigned HDR_MAGIC_MSB = 31;
  localparam int unsigned HDR_MAGIC_LSB = 24;
  localparam int unsigned HDR_LEN_MSB   = 15;
  localparam int unsigned HDR_LEN_LSB   = 8;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    TRAIL,
    DROP
  } state_e;

endpackage

// File: rtl/cell_packet_checker_if.sv
// 32-bit AXI-Stream bundle used for both the input and output of the checker.
interface cell_packet_checker_if;

  logic        TVALID;
  logic        TREADY;
  logic [31:0] TDATA;
  logic        TLAST;

  modport master (output TVALID, output TDATA, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);

endinterface

// File: rtl/cell_pkt_ram.sv
// Simple dual-port buffer RAM: one write port, one read port whose registered
// output holds its value whenever no read is issued.
module cell_pkt_ram #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 33
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cell_packet_checker.sv
// Store-and-forward packet validator: magic, length and (with
// CELL_PKT_CHECKSUM_EN defined) additive checksum; bad packets are rewound.
module cell_packet_checker
  import cell_pkt_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [7:0]  MAGIC      = MAGIC_DEFAULT
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  cell_packet_checker_if.slave  S00_AXIS,
  cell_packet_checker_if.master M00_AXIS,
  input  logic                  COUNT_CLEAR,
  output logic [COUNT_W-1:0]    GOOD_COUNT,
  output logic [COUNT_W-1:0]    BAD_MAGIC_COUNT,
  output logic [COUNT_W-1:0]    BAD_LENGTH_COUNT,
  output logic [COUNT_W-1:0]    BAD_CSUM_COUNT
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [7:0]    remain_q, remain_d;
  logic          rst_done_q, out_valid_q;
  logic          s_ready, s_acc, wr_en, full, rd_en;
  logic          inc_good, inc_magic, inc_len;
  logic [32:0]   rd_data;
  logic [COUNT_W-1:0] good_cnt_q, magic_cnt_q, len_cnt_q;

  // Full when the wrap bits differ and the low bits match.
  assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign s_ready = rst_done_q && ((state_q == DROP) || !full);
  assign s_acc   = S00_AXIS.TVALID && s_ready;
  assign wr_en   = s_acc && (state_q != DROP);
  assign S00_AXIS.TREADY = s_ready;

`ifdef CELL_PKT_CHECKSUM_EN
  logic [31:0]        sum_q, sum_d;
  logic               inc_csum;
  logic [COUNT_W-1:0] csum_cnt_q;

  always_comb begin
    sum_d = sum_q;
    if (s_acc && state_q == HDR)     sum_d = S00_AXIS.TDATA;
    if (s_acc && state_q == PAYLOAD) sum_d = sum_q + S00_AXIS.TDATA;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)         csum_cnt_q <= '0;
    else if (COUNT_CLEAR) csum_cnt_q <= '0;
    else if (inc_csum)    csum_cnt_q <= csum_cnt_q + COUNT_W'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign BAD_CSUM_COUNT = csum_cnt_q;
`else
  assign BAD_CSUM_COUNT = '0;
`endif

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    commit_ptr_d = commit_ptr_q;
    wr_ptr_d     = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    inc_good     = 1'b0;
    inc_magic    = 1'b0;
    inc_len      = 1'b0;
`ifdef CELL_PKT_CHECKSUM_EN
    inc_csum     = 1'b0;
`endif
    if (s_acc) begin
      unique case (state_q)
        HDR: begin
          if (S00_AXIS.TDATA[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != MAGIC) begin
            inc_magic = 1'b1;
            wr_ptr_d  = commit_ptr_q;
            state_d   = S00_AXIS.TLAST ? HDR : DROP;
          end else if (S00_AXIS.TLAST) begin
            inc_len  = 1'b1;
            wr_ptr_d = commit_ptr_q;
          end else begin
            remain_d = S00_AXIS.TDATA[HDR_LEN_MSB:HDR_LEN_LSB];
            state_d  = (remain_d == 8'd0) ? TRAIL : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (S00_AXIS.TLAST) begin
            inc_len  = 1'b1;
            wr_ptr_d = commit_ptr_q;
            state_d  = HDR;
          end else begin
            remain_d = remain_q - 8'd1;
            if (remain_q == 8'd1) state_d = TRAIL;
          end
        end
        TRAIL: begin
          if (!S00_AXIS.TLAST) begin
            inc_len  = 1'b1;
            wr_ptr_d = commit_ptr_q;
            state_d  = DROP;
          end
`ifdef CELL_PKT_CHECKSUM_EN
          else if (S00_AXIS.TDATA != sum_q) begin
            inc_csum = 1'b1;
            wr_ptr_d = commit_ptr_q;
            state_d  = HDR;
          end
`endif
          else begin
            inc_good     = 1'b1;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            state_d      = HDR;
          end
        end
        DROP: begin
          if (S00_AXIS.TLAST) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= HDR;
      remain_q     <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rst_done_q   <= 1'b1;
    end
  end

  // The RAM read register doubles as the output register, so it only
  // advances when empty or when the downstream takes the current word.
  assign rd_en = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || M00_AXIS.TREADY);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rd_en)                out_valid_q <= 1'b1;
      else if (M00_AXIS.TREADY) out_valid_q <= 1'b0;
    end
  end

  cell_pkt_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(33)
  ) u_ram (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i ({S00_AXIS.TLAST, S00_AXIS.TDATA}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rd_data)
  );

  assign M00_AXIS.TVALID = out_valid_q;
  assign M00_AXIS.TDATA  = rd_data[31:0];
  assign M00_AXIS.TLAST  = rd_data[32];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      good_cnt_q  <= '0;
      magic_cnt_q <= '0;
      len_cnt_q   <= '0;
    end else if (COUNT_CLEAR) begin
      good_cnt_q  <= '0;
      magic_cnt_q <= '0;
      len_cnt_q   <= '0;
    end else begin
      if (inc_good)  good_cnt_q  <= good_cnt_q  + COUNT_W'(1);
      if (inc_magic) magic_cnt_q <= magic_cnt_q + COUNT_W'(1);
      if (inc_len)   len_cnt_q   <= len_cnt_q   + COUNT_W'(1);
    end
  end

  assign GOOD_COUNT       = good_cnt_q;
  assign BAD_MAGIC_COUNT  = magic_cnt_q;
  assign BAD_LENGTH_COUNT = len_cnt_q;

endmodule

// File: tb/tb_cell_packet_checker.sv
// Directed bench for cell_packet_checker: good/bad packets, counters, latency,
// backpressure to full, reset mid-packet and count-clear collisions.
module tb_cell_packet_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic [15:0] good, bmag, blen, bcsum;

  always #5 clk = ~clk;

  cell_packet_checker_if s_if ();
  cell_packet_checker_if m_if ();

  cell_packet_checker #(
    .ADDR_WIDTH(9),
    .MAGIC(8'hA5)
  ) dut (
    .ACLK             (clk),
    .ARESETN          (rstn),
    .S00_AXIS         (s_if),
    .M00_AXIS         (m_if),
    .COUNT_CLEAR      (clr),
    .GOOD_COUNT       (good),
    .BAD_MAGIC_COUNT  (bmag),
    .BAD_LENGTH_COUNT (blen),
    .BAD_CSUM_COUNT   (bcsum)
  );

  int          errors = 0;
  int          checks = 0;
  bit          abort  = 0;
  logic [32:0] outq [$];
  logic [32:0] expq [$];
  logic [31:0] pkt  [$];

  always @(negedge clk) begin
    if (rstn === 1'b1 && m_if.TVALID === 1'b1 && m_if.TREADY === 1'b1)
      outq.push_back({m_if.TLAST, m_if.TDATA});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic c, output int waits);
    waits = 0;
    if (abort) return;
    s_if.TVALID = 1'b1;
    s_if.TDATA  = d;
    s_if.TLAST  = l;
    clr         = c;
    while (s_if.TREADY !== 1'b1 && waits < 3000) begin
      step();
      waits++;
    end
    if (waits >= 3000) begin
      abort = 1;
      chk("send_timeout", 64'(s_if.TREADY), 64'd1);
    end else begin
      step();
    end
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic send_pkt(input bit exp_out);
    int w;
    for (int i = 0; i < pkt.size(); i++) begin
      send_word(pkt[i], (i == pkt.size() - 1), 1'b0, w);
      if (exp_out) expq.push_back({(i == pkt.size() - 1) ? 1'b1 : 1'b0, pkt[i]});
    end
  endtask

  task automatic check_out(input string tag);
    int n = 0;
    while (outq.size() < expq.size() && n < 3000) begin
      step();
      n++;
    end
    repeat (5) step();
    chk({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(outq[i]), 64'(expq[i]));
    outq.delete();
    expq.delete();
  endtask

  task automatic check_counts(input string tag, input int g, input int m, input int l, input int c);
    chk({tag, "_good"}, 64'(good), 64'(g));
    chk({tag, "_bad_magic"}, 64'(bmag), 64'(m));
    chk({tag, "_bad_len"}, 64'(blen), 64'(l));
    chk({tag, "_bad_csum"}, 64'(bcsum), 64'(c));
  endtask

  initial begin
    int          w;
    bit          stalled;
    logic [31:0] d, sum;

    rstn        = 1'b0;
    clr         = 1'b0;
    s_if.TVALID = 1'b0;
    s_if.TDATA  = '0;
    s_if.TLAST  = 1'b0;
    m_if.TREADY = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_s_tready", 64'(s_if.TREADY), 64'd0);
    chk("rst_m_tvalid", 64'(m_if.TVALID), 64'd0);
    chk("rst_m_tdata", 64'(m_if.TDATA), 64'd0);
    chk("rst_m_tlast", 64'(m_if.TLAST), 64'd0);
    check_counts("rst", 0, 0, 0, 0);
    rstn = 1'b1;
    step();
    chk("rst_release_tready", 64'(s_if.TREADY), 64'd1);

    // Good packet, with first-word latency
    pkt = '{32'hA5030200, 32'h00000001, 32'h00000002, 32'hA5030203};
    send_pkt(1'b1);
    chk("lat_t1_tvalid", 64'(m_if.TVALID), 64'd0);
    step();
    chk("lat_t2_tvalid", 64'(m_if.TVALID), 64'd1);
    chk("lat_t2_tdata", 64'(m_if.TDATA), 64'hA5030200);
    check_out("good");
    check_counts("good", 1, 0, 0, 0);

    // Bad magic, then a good packet passes unaltered
    pkt = '{32'h5A030100, 32'h00000007, 32'h00000008};
    send_pkt(1'b0);
    pkt = '{32'hA5010105, 32'h00000010, 32'hA5010115};
    send_pkt(1'b1);
    check_out("magic");
    check_counts("magic", 2, 1, 0, 0);

    // Early TLAST on payload word 2 of an N=3 packet
    pkt = '{32'hA5020300, 32'h00000001, 32'h00000002};
    send_pkt(1'b0);
    check_out("early");
    chk("early_wr_ptr", 64'(dut.wr_ptr_q), 64'd7);
    chk("early_commit_ptr", 64'(dut.commit_ptr_q), 64'd7);
    check_counts("early", 2, 1, 1, 0);

    // Trailer missing TLAST; following words dropped with TREADY high
    send_word(32'hA5040100, 1'b0, 1'b0, w);
    send_word(32'h00000005, 1'b0, 1'b0, w);
    send_word(32'h12345678, 1'b0, 1'b0, w);
    send_word(32'h00000001, 1'b0, 1'b0, w);
    chk("drop_wait1", 64'(w), 64'd0);
    send_word(32'h00000002, 1'b1, 1'b0, w);
    chk("drop_wait2", 64'(w), 64'd0);
    check_out("notlast");
    chk("notlast_wr_ptr", 64'(dut.wr_ptr_q), 64'd7);
    check_counts("notlast", 2, 1, 2, 0);

    // Checksum off by one
    pkt = '{32'hA5060100, 32'h00000003, 32'hA5060104};
`ifdef CELL_PKT_CHECKSUM_EN
    send_pkt(1'b0);
    check_out("csum");
    check_counts("csum", 2, 1, 2, 1);
`else
    send_pkt(1'b1);
    check_out("csum");
    check_counts("csum", 3, 1, 2, 0);
`endif

    // COUNT_CLEAR coincident with a commit
    send_word(32'hA5070000, 1'b0, 1'b0, w);
    send_word(32'hA5070000, 1'b1, 1'b1, w);
    expq.push_back({1'b0, 32'hA5070000});
    expq.push_back({1'b1, 32'hA5070000});
    check_out("clear");
    check_counts("clear", 0, 0, 0, 0);

    // Stream max-length packets into a stalled output until full, then drain
    m_if.TREADY = 1'b0;
    stalled     = 0;
    for (int p = 0; p < 3; p++) begin
      sum = '0;
      for (int i = 0; i < 257; i++) begin
        if (i == 0)        d = 32'hA500FF00 | (32'(p) << 16) | 32'(p);
        else if (i < 256)  d = 32'h10000000 | (32'(p) << 12) | 32'(i);
        else               d = sum;
        if (i < 256) sum = sum + d;
        expq.push_back({(i == 256) ? 1'b1 : 1'b0, d});
        if (!stalled && s_if.TREADY === 1'b0 && m_if.TREADY === 1'b0) begin
          stalled = 1;
          chk("stall_tvalid", 64'(m_if.TVALID), 64'd1);
          chk("stall_tdata", 64'(m_if.TDATA), 64'hA500FF00);
          repeat (4) step();
          chk("stall_hold_tready", 64'(s_if.TREADY), 64'd0);
          chk("stall_hold_tdata", 64'(m_if.TDATA), 64'hA500FF00);
          m_if.TREADY = 1'b1;
        end
        send_word(d, (i == 256), 1'b0, w);
      end
    end
    chk("stall_seen", 64'(stalled), 64'd1);
    m_if.TREADY = 1'b1;
    check_out("stress");
    check_counts("stress", 3, 0, 0, 0);

    // Reset mid-packet with committed data waiting downstream
    m_if.TREADY = 1'b0;
    pkt = '{32'hA5080000, 32'hA5080000};
    send_pkt(1'b0);
    send_word(32'hA5090200, 1'b0, 1'b0, w);
    send_word(32'h00000001, 1'b0, 1'b0, w);
    chk("prerst_tvalid", 64'(m_if.TVALID), 64'd1);
    chk("prerst_tdata", 64'(m_if.TDATA), 64'hA5080000);
    rstn = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_if.TVALID), 64'd0);
    chk("midrst_tdata", 64'(m_if.TDATA), 64'd0);
    chk("midrst_tlast", 64'(m_if.TLAST), 64'd0);
    chk("midrst_s_tready", 64'(s_if.TREADY), 64'd0);
    check_counts("midrst", 0, 0, 0, 0);
    step();
    step();
    rstn        = 1'b1;
    m_if.TREADY = 1'b1;
    repeat (10) step();
    chk("postrst_no_output", 64'(outq.size()), 64'd0);
    chk("postrst_tvalid", 64'(m_if.TVALID), 64'd0);
    pkt = '{32'hA50A0000, 32'hA50A0000};
    send_pkt(1'b1);
    check_out("postrst");
    check_counts("postrst", 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
